// File: rtl/mmc1_serial_writer_if.sv
// mmc1_serial_writer_if
// Request handshake and CPU-bus strobes of the MMC1 serial writer, grouped
// so the host side and the writer side connect through one bundle.
//   master : the requester (issues req_*, observes status and CPU bus)
//   slave  : the serial writer (accepts req_*, drives status and CPU bus)
interface mmc1_serial_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_reg;
  logic [4:0]  req_value;
  logic        req_rst;
  logic        busy;
  logic        done;
  logic        m2;
  logic        cpu_rw_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;

  modport master (
    output req_valid, req_reg, req_value, req_rst,
    input  req_ready, busy, done, m2, cpu_rw_n, cpu_addr, cpu_data
  );

  modport slave (
    input  req_valid, req_reg, req_value, req_rst,
    output req_ready, busy, done, m2, cpu_rw_n, cpu_addr, cpu_data
  );
endinterface

// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer
// Master end of the MMC1 serial register port. One accepted request becomes
// either five CPU write cycles (value bits LSB first on D0) or a single
// shift-reset write (D7=1) to $8000/$A000/$C000/$E000. Every write cycle is
// followed by GAP_CYCLES idle CPU cycles, so the mapper never sees two writes
// in adjacent CPU cycles and its consecutive-write filter never drops a bit.
//
// Optional feature macro: MMC1_WR_PRERESET_EN
//   When defined, every value transfer is prefixed with a shift-reset write
//   (plus its gap) to the target register, so a partial shift left behind by
//   an aborted transfer can never corrupt the next value.
//
// All outputs are registered; they are computed from the next-state values
// so the bus lines change exactly on the clock where the CPU cycle starts.
module mmc1_serial_writer #(
  parameter int CPU_DIV    = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic                  clk,
  input logic                  nres,
  mmc1_serial_writer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int PW = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(CPU_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CPU_DIV / 2);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

`ifdef MMC1_WR_PRERESET_EN
  localparam logic [2:0] VAL_LAST_IDX = 3'd5;
`else
  localparam logic [2:0] VAL_LAST_IDX = 3'd4;
`endif

  // Index of the final write of a transfer: a reset transfer is one write.
  function automatic logic [2:0] last_idx(input logic rst_x);
    if (rst_x) begin
      return 3'd0;
    end else begin
      return VAL_LAST_IDX;
    end
  endfunction

  // Selects one value bit by write index; out-of-range indices give 0.
  function automatic logic sel_bit(input logic [4:0] val, input logic [2:0] idx);
    case (idx)
      3'd0:    return val[0];
      3'd1:    return val[1];
      3'd2:    return val[2];
      3'd3:    return val[3];
      3'd4:    return val[4];
      default: return 1'b0;
    endcase
  endfunction

  // Data byte for write number idx of the captured transfer.
  function automatic logic [7:0] wr_data(input logic rst_x, input logic [4:0] val,
                                         input logic [2:0] idx);
    if (rst_x) begin
      return 8'h80;
    end else begin
`ifdef MMC1_WR_PRERESET_EN
      if (idx == 3'd0) begin
        return 8'h80;
      end else begin
        return {7'b0000000, sel_bit(val, idx - 3'd1)};
      end
`else
      return {7'b0000000, sel_bit(val, idx)};
`endif
    end
  endfunction

  // Sequencer state
  logic [1:0]    state_r,  state_s;
  logic [PW-1:0] phase_r,  phase_s;
  logic [GW-1:0] gap_r,    gap_s;
  logic [2:0]    idx_r,    idx_s;
  logic [1:0]    reg_r,    reg_s;
  logic [4:0]    value_r,  value_s;
  logic          rst_x_r,  rst_x_s;
  logic [PW-1:0] phase_adv_s;

  // Registered outputs and their next values
  logic          ready_r,  ready_s;
  logic          busy_r,   busy_s;
  logic          done_r,   done_s;
  logic          m2_r,     m2_s;
  logic          rw_n_r,   rw_n_s;
  logic [15:0]   addr_r,   addr_s;
  logic [7:0]    data_r,   data_s;

  // Next-state logic: request capture, CPU-cycle phase and write/gap sequencing.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    gap_s   = gap_r;
    idx_s   = idx_r;
    reg_s   = reg_r;
    value_s = value_r;
    rst_x_s = rst_x_r;

    if (phase_r == PH_LAST) begin
      phase_adv_s = {PW{1'b0}};
    end else begin
      phase_adv_s = phase_r + PH_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        phase_s = {PW{1'b0}};
        if (bus.req_valid) begin
          state_s = ST_WR;
          gap_s   = {GW{1'b0}};
          idx_s   = 3'd0;
          reg_s   = bus.req_reg;
          value_s = bus.req_value;
          rst_x_s = bus.req_rst;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        phase_s = phase_adv_s;
        if (phase_r == PH_LAST) begin
          state_s = ST_GAP;
          gap_s   = {GW{1'b0}};
        end else begin
          state_s = ST_WR;
        end
      end
      ST_GAP: begin
        phase_s = phase_adv_s;
        if (phase_r == PH_LAST) begin
          if (gap_r == GAP_LAST) begin
            if (idx_r == last_idx(rst_x_r)) begin
              state_s = ST_IDLE;
              phase_s = {PW{1'b0}};
            end else begin
              state_s = ST_WR;
              idx_s   = idx_r + 3'd1;
            end
          end else begin
            gap_s = gap_r + GAP_ONE;
          end
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = {PW{1'b0}};
        gap_s   = {GW{1'b0}};
        idx_s   = 3'd0;
      end
    endcase
  end

  // Output decode from next state so every bus line is a clean register.
  always_comb begin
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s != ST_IDLE);
    m2_s    = (state_s != ST_IDLE) && (phase_s >= PH_HALF);
    done_s  = (state_s == ST_GAP) && (phase_s == PH_LAST) &&
              (gap_s == GAP_LAST) && (idx_s == last_idx(rst_x_s));
    if (state_s == ST_WR) begin
      rw_n_s = 1'b0;
      addr_s = {1'b1, reg_s, 13'h0000};
      data_s = wr_data(rst_x_s, value_s, idx_s);
    end else begin
      rw_n_s = 1'b1;
      addr_s = 16'h0000;
      data_s = 8'h00;
    end
  end

  // State and output registers; reset discards any partial transfer at once.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_r <= ST_IDLE;
      phase_r <= {PW{1'b0}};
      gap_r   <= {GW{1'b0}};
      idx_r   <= 3'd0;
      reg_r   <= 2'd0;
      value_r <= 5'd0;
      rst_x_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      m2_r    <= 1'b0;
      rw_n_r  <= 1'b1;
      addr_r  <= 16'h0000;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      gap_r   <= gap_s;
      idx_r   <= idx_s;
      reg_r   <= reg_s;
      value_r <= value_s;
      rst_x_r <= rst_x_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      m2_r    <= m2_s;
      rw_n_r  <= rw_n_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.m2        = m2_r;
  assign bus.cpu_rw_n  = rw_n_r;
  assign bus.cpu_addr  = addr_r;
  assign bus.cpu_data  = data_r;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// tb_mmc1_serial_writer
// Directed bench for mmc1_serial_writer with default parameters
// (CPU_DIV=4, GAP_CYCLES=1). Each clock of a transfer is compared against
// the expected bus picture; expected write bytes are hand-computed per test.
// Honours MMC1_WR_PRERESET_EN the same way the design does.
module tb_mmc1_serial_writer;

  logic clk;
  logic nres;
  int   checks;
  int   failures;

  mmc1_serial_writer_if ifc();

  mmc1_serial_writer #(.CPU_DIV(4), .GAP_CYCLES(1)) dut (
    .clk  (clk),
    .nres (nres),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MMC1_WR_PRERESET_EN
  localparam int VLEN = 48;
`else
  localparam int VLEN = 40;
`endif
  localparam int RLEN = 8;

  // {ready, busy, done, m2, rw_n, addr[15:0], data[7:0]}
  localparam logic [28:0] IDLE_V = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};

  function automatic logic [28:0] obs();
    return {ifc.req_ready, ifc.busy, ifc.done, ifc.m2, ifc.cpu_rw_n,
            ifc.cpu_addr, ifc.cpu_data};
  endfunction

  // Expected bus picture on clock n (1 = first clock after accept) of a
  // transfer lasting len clocks; each write is 4 clocks followed by a 4-clock gap.
  function automatic logic [28:0] exp_vec(int n, int len, logic [1:0] rg, logic [47:0] dp);
    int   ph;
    int   j;
    logic inwr;
    logic [15:0] a;
    logic [7:0]  d;
    ph   = (n - 1) % 4;
    j    = (n - 1) / 8;
    inwr = ((n - 1) % 8) < 4;
    a    = inwr ? {1'b1, rg, 13'h0000} : 16'h0000;
    d    = inwr ? dp[j*8 +: 8] : 8'h00;
    return {1'b0, 1'b1, (n == len), (ph >= 2), !inwr, a, d};
  endfunction

  task automatic chk(input string tag, input logic [28:0] o, input logic [28:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called at a negedge with the request already driven. Accepts on the next
  // edge and checks every clock. With hold, req_valid stays high and the
  // request fields switch to nreg/nval after accept (they must be ignored).
  // abort_at>0 pulses nres low right after checking that clock.
  task automatic run_xfer(input string tag, input logic [1:0] rg, input int len,
                          input logic [47:0] dp, input bit hold,
                          input logic [1:0] nreg, input logic [4:0] nval,
                          input int abort_at);
    @(posedge clk);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      chk($sformatf("%s_clk%0d", tag, n), obs(), exp_vec(n, len, rg, dp));
      if (hold) begin
        ifc.req_reg   = nreg;
        ifc.req_value = nval;
        ifc.req_rst   = 1'b0;
      end else begin
        ifc.req_valid = 1'b0;
      end
      if (n == abort_at) begin
        nres = 1'b0;
        #1;
        chk($sformatf("%s_abort_now", tag), obs(), IDLE_V);
        @(negedge clk);
        chk($sformatf("%s_abort_held", tag), obs(), IDLE_V);
        nres = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("%s_end", tag), obs(), IDLE_V);
  endtask

  task automatic drive(input logic [1:0] rg, input logic [4:0] val, input logic rst);
    ifc.req_valid = 1'b1;
    ifc.req_reg   = rg;
    ifc.req_value = val;
    ifc.req_rst   = rst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    nres          = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_reg   = 2'd0;
    ifc.req_value = 5'd0;
    ifc.req_rst   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_held", obs(), IDLE_V);
    nres = 1'b1;
    @(negedge clk);
    chk("reset_released", obs(), IDLE_V);

    // 1: value 01100 to $8000 -> d0 = 0,0,1,1,0
    drive(2'd0, 5'b01100, 1'b0);
`ifdef MMC1_WR_PRERESET_EN
    run_xfer("t1", 2'd0, VLEN, 48'h00_01_01_00_00_80, 1'b0, 2'd0, 5'd0, 0);
`else
    run_xfer("t1", 2'd0, VLEN, 48'h00_00_01_01_00_00, 1'b0, 2'd0, 5'd0, 0);
`endif

    // 2: reset transfer wins over value 1F -> single 80 write to $8000
    drive(2'd0, 5'h1F, 1'b1);
    run_xfer("t2", 2'd0, RLEN, 48'h00_00_00_00_00_80, 1'b0, 2'd0, 5'd0, 0);

    // 3: value 1F to $E000 -> five writes of 01
    drive(2'd3, 5'h1F, 1'b0);
`ifdef MMC1_WR_PRERESET_EN
    run_xfer("t3", 2'd3, VLEN, 48'h01_01_01_01_01_80, 1'b0, 2'd0, 5'd0, 0);
`else
    run_xfer("t3", 2'd3, VLEN, 48'h00_01_01_01_01_01, 1'b0, 2'd0, 5'd0, 0);
`endif

    // 4: req_valid held high; fields change mid-transfer and must be ignored.
    //    First: $A000 value 10110 (0,1,1,0,1). Second: $C000 value 00001.
    drive(2'd1, 5'b10110, 1'b0);
`ifdef MMC1_WR_PRERESET_EN
    run_xfer("t4a", 2'd1, VLEN, 48'h01_00_01_01_00_80, 1'b1, 2'd2, 5'b00001, 0);
    run_xfer("t4b", 2'd2, VLEN, 48'h00_00_00_00_01_80, 1'b0, 2'd0, 5'd0, 0);
`else
    run_xfer("t4a", 2'd1, VLEN, 48'h00_01_00_01_01_00, 1'b1, 2'd2, 5'b00001, 0);
    run_xfer("t4b", 2'd2, VLEN, 48'h00_00_00_00_00_01, 1'b0, 2'd0, 5'd0, 0);
`endif

    // 5: value 01010 aborted by nres during the 3rd write (clock 18)
    drive(2'd0, 5'b01010, 1'b0);
`ifdef MMC1_WR_PRERESET_EN
    run_xfer("t5a", 2'd0, VLEN, 48'h00_01_00_01_00_80, 1'b0, 2'd0, 5'd0, 18);
`else
    run_xfer("t5a", 2'd0, VLEN, 48'h00_00_01_00_01_00, 1'b0, 2'd0, 5'd0, 18);
`endif
    @(negedge clk);
    chk("t5_after_release", obs(), IDLE_V);

    // 5/6: fresh transfer after abort, value 10101 to $8000
    drive(2'd0, 5'h15, 1'b0);
`ifdef MMC1_WR_PRERESET_EN
    run_xfer("t6", 2'd0, VLEN, 48'h01_00_01_00_01_80, 1'b0, 2'd0, 5'd0, 0);
`else
    run_xfer("t6", 2'd0, VLEN, 48'h00_01_00_01_00_01, 1'b0, 2'd0, 5'd0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
